dma_transfer_sequencer: RTL and testbench

Timing-and-control stage directly upstream of the address and count register file in the KF8237 DMA controller. Resolves channel requests against fixed priority and runs the 8237 bus cycle state machine (SI, S0, S1, S2, S3, S4, SC). Drives the per-transfer control strobes into the register file (transfer_register_select, next_word, initialize_current_register, decrement_address_config) and consumes its underflow and transfer_address outputs. Generates the external bus handshake (HRQ/HLDA, DACK, AEN, ADSTB, read/write strobes, EOP, TC status).

---
 rtl/dma_transfer_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dma_transfer_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_transfer_sequencer.sv
// Priority resolver and 8237 bus-cycle state machine (SI/S0/S1/S2/S3/S4/SC) driving the
// KF8237 address/count register file. Optional macro COMPRESSED_TIMING_EN drops S3 in bursts.
module dma_transfer_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  dma_request,
   input  logic [3:0]  channel_mask,
   input  logic [31:0] mode_register,
   input  logic        controller_disable,
   input  logic        hold_acknowledge,
   input  logic        end_of_process_in,
   input  logic        underflow,
   input  logic [15:0] transfer_address,
   output logic        hold_request,
   output logic [3:0]  dma_acknowledge,
   output logic        address_enable,
   output logic        address_strobe,
   output logic        memory_read,
   output logic        memory_write,
   output logic        io_read,
   output logic        io_write,
   output logic        end_of_process_out,
   output logic [3:0]  terminal_count_status,
   input  logic        clear_terminal_count,
   output logic [3:0]  transfer_register_select,
   output logic        initialize_current_register,
   output logic        decrement_address_config,
   output logic        next_word
);

   typedef enum logic [2:0] {
      ST_SI = 3'd0,
      ST_S0 = 3'd1,
      ST_S1 = 3'd2,
      ST_S2 = 3'd3,
      ST_S3 = 3'd4,
      ST_S4 = 3'd5,
      ST_SC = 3'd6
   } state_t;

   function automatic logic [7:0] mode_byte(input logic [31:0] m, input logic [1:0] c);
      case (c)
         2'd0:    mode_byte = m[7:0];
         2'd1:    mode_byte = m[15:8];
         2'd2:    mode_byte = m[23:16];
         default: mode_byte = m[31:24];
      endcase
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] c);
      case (c)
         2'd0:    onehot4 = 4'b0001;
         2'd1:    onehot4 = 4'b0010;
         2'd2:    onehot4 = 4'b0100;
         default: onehot4 = 4'b1000;
      endcase
   endfunction

   state_t      state_r;
   state_t      state_next;
   logic [1:0]  ch_r;
   logic [1:0]  ch_next;
   logic [3:0]  pending_s;
   logic [1:0]  winner_s;
   logic [7:0]  cur_mode_s;
   logic [7:0]  next_mode_s;
   logic        tc_s;
   logic        low_zero_s;
   logic        compress_s;
   logic        compress_next_s;
   logic [3:0]  tc_set_s;

   logic        hold_request_d;
   logic [3:0]  dma_acknowledge_d;
   logic        address_enable_d;
   logic        address_strobe_d;
   logic        memory_read_d;
   logic        memory_write_d;
   logic        io_read_d;
   logic        io_write_d;
   logic [3:0]  transfer_register_select_d;
   logic        decrement_address_config_d;
   logic        next_word_d;
   logic        active_d;
   logic        read_phase_d;
   logic        write_phase_d;

   logic        unused_s;

   assign pending_s   = controller_disable ? 4'b0000 : (dma_request & ~channel_mask);
   assign cur_mode_s  = mode_byte(mode_register, ch_r);
   assign next_mode_s = mode_byte(mode_register, ch_next);
   assign tc_s        = underflow | end_of_process_in;
   assign low_zero_s  = (transfer_address[7:0] == 8'h00);
   assign unused_s    = ^{transfer_address[15:8], cur_mode_s, next_mode_s};

`ifdef COMPRESSED_TIMING_EN
   // Demand (00) and block (10) bursts fold the write strobe into S2 and skip S3.
   assign compress_s      = (cur_mode_s[7:6] == 2'b00) || (cur_mode_s[7:6] == 2'b10);
   assign compress_next_s = (next_mode_s[7:6] == 2'b00) || (next_mode_s[7:6] == 2'b10);
`else
   assign compress_s      = 1'b0;
   assign compress_next_s = 1'b0;
`endif

   // Fixed priority: channel 0 highest.
   always_comb begin
      winner_s = 2'd3;
      if (pending_s[0]) begin
         winner_s = 2'd0;
      end else if (pending_s[1]) begin
         winner_s = 2'd1;
      end else if (pending_s[2]) begin
         winner_s = 2'd2;
      end else begin
         winner_s = 2'd3;
      end
   end

   // Bus-cycle next-state and channel latch.
   always_comb begin
      state_next = state_r;
      ch_next    = ch_r;
      case (state_r)
         ST_SI: begin
            if (|pending_s) begin
               state_next = ST_S0;
               ch_next    = winner_s;
            end else begin
               state_next = ST_SI;
            end
         end
         ST_S0: begin
            if (!pending_s[ch_r]) begin
               state_next = ST_SI;
            end else if (hold_acknowledge) begin
               state_next = ST_S1;
            end else begin
               state_next = ST_S0;
            end
         end
         ST_S1: begin
            if (!hold_acknowledge) begin
               state_next = ST_SI;
            end else begin
               state_next = ST_S2;
            end
         end
         ST_S2: begin
            if (!hold_acknowledge) begin
               state_next = ST_SI;
            end else if (compress_s) begin
               state_next = ST_S4;
            end else begin
               state_next = ST_S3;
            end
         end
         ST_S3: begin
            if (!hold_acknowledge) begin
               state_next = ST_SI;
            end else begin
               state_next = ST_S4;
            end
         end
         ST_S4: begin
            if (!hold_acknowledge) begin
               state_next = ST_SI;
            end else begin
               state_next = ST_SC;
            end
         end
         ST_SC: begin
            if (tc_s || !hold_acknowledge) begin
               state_next = ST_SI;
            end else begin
               // A zero low address byte means the upper byte changed and must be re-strobed.
               case (cur_mode_s[7:6])
                  2'b00: begin
                     if (dma_request[ch_r]) begin
                        state_next = low_zero_s ? ST_S1 : ST_S2;
                     end else begin
                        state_next = ST_SI;
                     end
                  end
                  2'b10:   state_next = low_zero_s ? ST_S1 : ST_S2;
                  default: state_next = ST_SI;
               endcase
            end
         end
         default: begin
            state_next = ST_SI;
            ch_next    = 2'd0;
         end
      endcase
   end

   // Output values for the state being entered, registered alongside it.
   always_comb begin
      active_d      = (state_next == ST_S1) || (state_next == ST_S2) || (state_next == ST_S3) ||
                      (state_next == ST_S4) || (state_next == ST_SC);
      read_phase_d  = (state_next == ST_S2) || (state_next == ST_S3) || (state_next == ST_S4);
      write_phase_d = (state_next == ST_S3) || (state_next == ST_S4) ||
                      ((state_next == ST_S2) && compress_next_s);
      hold_request_d             = (state_next != ST_SI);
      address_enable_d           = active_d;
      address_strobe_d           = (state_next == ST_S1);
      next_word_d                = (state_next == ST_S4);
      dma_acknowledge_d          = active_d ? onehot4(ch_next) : 4'b0000;
      transfer_register_select_d = active_d ? onehot4(ch_next) : 4'b0000;
      decrement_address_config_d = active_d & next_mode_s[5];
      memory_read_d              = read_phase_d  & (next_mode_s[3:2] == 2'b10);
      io_write_d                 = write_phase_d & (next_mode_s[3:2] == 2'b10);
      io_read_d                  = read_phase_d  & (next_mode_s[3:2] == 2'b01);
      memory_write_d             = write_phase_d & (next_mode_s[3:2] == 2'b01);
   end

   // State, channel and bus outputs update on the falling edge.
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         state_r                  <= ST_SI;
         ch_r                     <= 2'd0;
         hold_request             <= 1'b0;
         dma_acknowledge          <= 4'b0000;
         address_enable           <= 1'b0;
         address_strobe           <= 1'b0;
         memory_read              <= 1'b0;
         memory_write             <= 1'b0;
         io_read                  <= 1'b0;
         io_write                 <= 1'b0;
         transfer_register_select <= 4'b0000;
         decrement_address_config <= 1'b0;
         next_word                <= 1'b0;
      end else begin
         state_r                  <= state_next;
         ch_r                     <= ch_next;
         hold_request             <= hold_request_d;
         dma_acknowledge          <= dma_acknowledge_d;
         address_enable           <= address_enable_d;
         address_strobe           <= address_strobe_d;
         memory_read              <= memory_read_d;
         memory_write             <= memory_write_d;
         io_read                  <= io_read_d;
         io_write                 <= io_write_d;
         transfer_register_select <= transfer_register_select_d;
         decrement_address_config <= decrement_address_config_d;
         next_word                <= next_word_d;
      end
   end

   // Terminal-count decisions are taken during SC itself, from the register-file underflow.
   assign tc_set_s = ((state_r == ST_SC) && tc_s) ? onehot4(ch_r) : 4'b0000;
   assign end_of_process_out          = (state_r == ST_SC) & underflow;
   assign initialize_current_register = (state_r == ST_SC) & tc_s & cur_mode_s[4];

   // Sticky TC flags; a set in the same cycle as a clear survives.
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         terminal_count_status <= 4'b0000;
      end else begin
         terminal_count_status <= (terminal_count_status & ~{4{clear_terminal_count}}) | tc_set_s;
      end
   end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Directed bench for dma_transfer_sequencer with a small address/count register-file model.
module tb_dma_transfer_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  dma_request;
   logic [3:0]  channel_mask;
   logic [31:0] mode_register;
   logic        controller_disable;
   logic        hold_acknowledge;
   logic        end_of_process_in;
   logic        clear_terminal_count;
   logic        hold_request;
   logic [3:0]  dma_acknowledge;
   logic        address_enable;
   logic        address_strobe;
   logic        memory_read;
   logic        memory_write;
   logic        io_read;
   logic        io_write;
   logic        end_of_process_out;
   logic [3:0]  terminal_count_status;
   logic [3:0]  transfer_register_select;
   logic        initialize_current_register;
   logic        decrement_address_config;
   logic        next_word;

   logic        underflow_m = 1'b0;
   logic [15:0] cnt_m = 16'd0;
   logic [15:0] addr_m = 16'd0;
   logic        load_en = 1'b0;
   logic [15:0] load_cnt = 16'd0;
   logic [15:0] load_addr = 16'd0;
   int          nw_count = 0;
   int          adstb_count = 0;
   int          eop_count = 0;

   int          n_compared = 0;
   int          n_mismatched = 0;

   dma_transfer_sequencer dut (
      .clock                       (clock),
      .reset                       (reset),
      .dma_request                 (dma_request),
      .channel_mask                (channel_mask),
      .mode_register               (mode_register),
      .controller_disable          (controller_disable),
      .hold_acknowledge            (hold_acknowledge),
      .end_of_process_in           (end_of_process_in),
      .underflow                   (underflow_m),
      .transfer_address            (addr_m),
      .hold_request                (hold_request),
      .dma_acknowledge             (dma_acknowledge),
      .address_enable              (address_enable),
      .address_strobe              (address_strobe),
      .memory_read                 (memory_read),
      .memory_write                (memory_write),
      .io_read                     (io_read),
      .io_write                    (io_write),
      .end_of_process_out          (end_of_process_out),
      .terminal_count_status       (terminal_count_status),
      .clear_terminal_count        (clear_terminal_count),
      .transfer_register_select    (transfer_register_select),
      .initialize_current_register (initialize_current_register),
      .decrement_address_config    (decrement_address_config),
      .next_word                   (next_word)
   );

   always #5 clock = ~clock;

   // Register-file model: underflow is flagged in the cycle after the word that used count 0.
   always @(negedge clock) begin
      if (load_en) begin
         cnt_m       <= load_cnt;
         addr_m      <= load_addr;
         underflow_m <= 1'b0;
      end else if (next_word) begin
         underflow_m <= (cnt_m == 16'd0);
         cnt_m       <= cnt_m - 16'd1;
         addr_m      <= decrement_address_config ? addr_m - 16'd1 : addr_m + 16'd1;
      end else begin
         underflow_m <= 1'b0;
      end
      if (next_word)          nw_count    <= nw_count + 1;
      if (address_strobe)     adstb_count <= adstb_count + 1;
      if (end_of_process_out) eop_count   <= eop_count + 1;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load_regs(input logic [15:0] c, input logic [15:0] a);
      load_cnt  = c;
      load_addr = a;
      load_en   = 1'b1;
      step();
      load_en   = 1'b0;
   endtask

   int  nw0;
   int  ad0;
   int  ev0;
   logic started;
   logic done;

   initial begin
      reset = 1'b1;
      dma_request = 4'b0000;
      channel_mask = 4'b0000;
      mode_register = 32'h0000_0000;
      controller_disable = 1'b0;
      hold_acknowledge = 1'b0;
      end_of_process_in = 1'b0;
      clear_terminal_count = 1'b0;
      step();
      step();
      check_value("rst_hrq", {31'd0, hold_request}, 32'd0);
      check_value("rst_dack", {28'd0, dma_acknowledge}, 32'd0);
      check_value("rst_tc", {28'd0, terminal_count_status}, 32'd0);
      check_value("rst_trs", {28'd0, transfer_register_select}, 32'd0);
      check_value("rst_strobes", {28'd0, memory_read, memory_write, io_read, io_write}, 32'd0);
      reset = 1'b0;
      step();

      // Single mode ch1, memory-to-IO, count 0.
      mode_register = {8'h00, 8'h00, 8'h48, 8'h00};
      load_regs(16'd0, 16'h1000);
      nw0 = nw_count;
      dma_request = 4'b0010;
      step();
      check_value("t1_s0_hrq", {31'd0, hold_request}, 32'd1);
      check_value("t1_s0_dack", {28'd0, dma_acknowledge}, 32'd0);
      hold_acknowledge = 1'b1;
      step();
      check_value("t1_s1_dack", {28'd0, dma_acknowledge}, 32'h2);
      check_value("t1_s1_aen_adstb", {30'd0, address_enable, address_strobe}, 32'h3);
      check_value("t1_s1_trs", {28'd0, transfer_register_select}, 32'h2);
      check_value("t1_s1_mr", {31'd0, memory_read}, 32'd0);
      step();
      check_value("t1_s2_rd_wr_adstb", {29'd0, memory_read, io_write, address_strobe}, 32'h4);
      step();
      check_value("t1_s3_rd_wr", {30'd0, memory_read, io_write}, 32'h3);
      check_value("t1_s3_nw", {31'd0, next_word}, 32'd0);
      step();
      check_value("t1_s4_nw_wr", {30'd0, next_word, io_write}, 32'h3);
      step();
      check_value("t1_sc_nw_mr", {30'd0, next_word, memory_read}, 32'd0);
      check_value("t1_sc_eop", {31'd0, end_of_process_out}, 32'd1);
      check_value("t1_sc_init", {31'd0, initialize_current_register}, 32'd0);
      dma_request = 4'b0000;
      step();
      check_value("t1_si_hrq_aen", {30'd0, hold_request, address_enable}, 32'd0);
      check_value("t1_si_eop", {31'd0, end_of_process_out}, 32'd0);
      check_value("t1_tc", {28'd0, terminal_count_status}, 32'h2);
      check_value("t1_nw_count", nw_count - nw0, 32'd1);
      hold_acknowledge = 1'b0;
      clear_terminal_count = 1'b1;
      step();
      clear_terminal_count = 1'b0;
      check_value("t1_tc_clear", {28'd0, terminal_count_status}, 32'd0);

      // Priority: ch0 (verify, single) beats ch3 (IO-to-memory, single).
      mode_register = {8'h44, 8'h00, 8'h00, 8'h40};
      load_regs(16'd5, 16'h3000);
      dma_request = 4'b1001;
      hold_acknowledge = 1'b1;
      step();
      step();
      check_value("t2_first_dack", {28'd0, dma_acknowledge}, 32'h1);
      dma_request = 4'b1000;
      step();
      check_value("t2_verify_strobes", {28'd0, memory_read, memory_write, io_read, io_write}, 32'd0);
      step();
      step();
      step();
      check_value("t2_sc_eop", {31'd0, end_of_process_out}, 32'd0);
      step();
      check_value("t2_si_dack", {28'd0, dma_acknowledge}, 32'd0);
      step();
      step();
      check_value("t2_second_dack", {28'd0, dma_acknowledge}, 32'h8);
      step();
      check_value("t2_s2_ior", {30'd0, io_read, memory_write}, 32'h2);
      dma_request = 4'b0000;
      step();
      check_value("t2_s3_ior_memw", {30'd0, io_read, memory_write}, 32'h3);
      step();
      step();
      step();
      check_value("t2_done_hrq", {31'd0, hold_request}, 32'd0);
      check_value("t2_tc", {28'd0, terminal_count_status}, 32'd0);

      // Demand mode ch2, count 3, address 0x00FE: four words, re-strobe at 0x0100.
      mode_register = {8'h00, 8'h08, 8'h00, 8'h00};
      load_regs(16'd3, 16'h00FE);
      nw0 = nw_count;
      ad0 = adstb_count;
      ev0 = eop_count;
      dma_request = 4'b0100;
      started = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         step();
         if (hold_request) started = 1'b1;
         else if (started) done = 1'b1;
      end
      dma_request = 4'b0000;
      check_value("t3_done", {31'd0, done}, 32'd1);
      check_value("t3_nw_count", nw_count - nw0, 32'd4);
      check_value("t3_adstb_count", adstb_count - ad0, 32'd2);
      check_value("t3_eop_count", eop_count - ev0, 32'd1);
      check_value("t3_tc", {28'd0, terminal_count_status}, 32'h4);
      check_value("t3_addr", {16'd0, addr_m}, 32'h0102);

      // Autoinit ch0, decrement, single; status clear collides with the TC set.
      mode_register = {8'h00, 8'h00, 8'h00, 8'h78};
      load_regs(16'd0, 16'h4000);
      dma_request = 4'b0001;
      step();
      step();
      check_value("t4_s1_trs", {28'd0, transfer_register_select}, 32'h1);
      check_value("t4_s1_dec", {31'd0, decrement_address_config}, 32'd1);
      step();
      step();
      step();
      step();
      check_value("t4_sc_init", {31'd0, initialize_current_register}, 32'd1);
      check_value("t4_sc_trs", {28'd0, transfer_register_select}, 32'h1);
      check_value("t4_sc_eop", {31'd0, end_of_process_out}, 32'd1);
      dma_request = 4'b0000;
      clear_terminal_count = 1'b1;
      step();
      clear_terminal_count = 1'b0;
      check_value("t4_si_init", {31'd0, initialize_current_register}, 32'd0);
      check_value("t4_si_trs_dec", {27'd0, transfer_register_select, decrement_address_config}, 32'd0);
      check_value("t4_tc_set_wins", {28'd0, terminal_count_status}, 32'h1);
      clear_terminal_count = 1'b1;
      step();
      clear_terminal_count = 1'b0;

      // External EOP during a block-mode burst on ch1.
      mode_register = {8'h00, 8'h00, 8'h84, 8'h00};
      load_regs(16'd10, 16'h2000);
      nw0 = nw_count;
      ev0 = eop_count;
      dma_request = 4'b0010;
      step();
      step();
      dma_request = 4'b0000;
      step();
      step();
      step();
      step();
      check_value("t5_sc_hrq", {31'd0, hold_request}, 32'd1);
      step();
      check_value("t5_burst_s2", {29'd0, io_read, memory_write, address_strobe}, 32'h4);
      end_of_process_in = 1'b1;
      step();
      step();
      step();
      check_value("t5_sc_eop_out", {31'd0, end_of_process_out}, 32'd0);
      step();
      end_of_process_in = 1'b0;
      check_value("t5_si_hrq", {31'd0, hold_request}, 32'd0);
      check_value("t5_tc", {28'd0, terminal_count_status}, 32'h2);
      check_value("t5_nw_count", nw_count - nw0, 32'd2);
      check_value("t5_eop_count", eop_count - ev0, 32'd0);

      // HLDA withdrawn in S2 on ch3.
      mode_register = {8'h48, 8'h00, 8'h00, 8'h00};
      load_regs(16'd5, 16'h5000);
      nw0 = nw_count;
      dma_request = 4'b1000;
      step();
      step();
      step();
      check_value("t6_s2_mr", {31'd0, memory_read}, 32'd1);
      hold_acknowledge = 1'b0;
      dma_request = 4'b0000;
      step();
      check_value("t6_abort_hrq_dack", {27'd0, hold_request, dma_acknowledge}, 32'd0);
      check_value("t6_abort_strobes", {27'd0, memory_read, memory_write, io_read, io_write, next_word}, 32'd0);
      check_value("t6_nw_count", nw_count - nw0, 32'd0);

      // Masked or disabled requests are ignored; request withdrawn in S0 returns to SI.
      channel_mask = 4'b0001;
      dma_request = 4'b0001;
      step();
      step();
      check_value("t7_masked", {31'd0, hold_request}, 32'd0);
      channel_mask = 4'b0000;
      controller_disable = 1'b1;
      step();
      step();
      check_value("t7_disabled", {31'd0, hold_request}, 32'd0);
      controller_disable = 1'b0;
      dma_request = 4'b0010;
      step();
      check_value("t7_s0_hrq", {31'd0, hold_request}, 32'd1);
      dma_request = 4'b0000;
      step();
      check_value("t7_s0_drop", {31'd0, hold_request}, 32'd0);

      // Reset in the middle of a transfer clears strobes without waiting for a clock edge.
      mode_register = {8'h00, 8'h00, 8'h00, 8'h48};
      load_regs(16'd5, 16'h6000);
      dma_request = 4'b0001;
      hold_acknowledge = 1'b1;
      step();
      step();
      step();
      step();
      check_value("t8_s3_wr", {30'd0, memory_read, io_write}, 32'h3);
      reset = 1'b1;
      #1;
      check_value("t8_async_strobes", {30'd0, memory_read, io_write}, 32'd0);
      check_value("t8_async_dack_hrq", {27'd0, hold_request, dma_acknowledge}, 32'd0);
      dma_request = 4'b0000;
      hold_acknowledge = 1'b0;
      step();
      reset = 1'b0;
      check_value("t8_tc_reset", {28'd0, terminal_count_status}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
